bmp_stream_parser: RTL

- Ingress stage directly upstream of image_processing_acclerator.
- Accepts a raw BMP file as a little-endian 32-bit word stream and parses and checks the BMP header.
- Discards header and gap bytes, then re-packs pixel-array bytes into aligned 32-bit words for the accelerator's slv0 data port.
- Flags the last word and reports header fields, completion and errors.

---
 rtl/bmp_pkg.sv | 44 ++++
 rtl/byte_packer.sv | 93 +++++++++
 rtl/bmp_stream_parser.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bmp_pkg.sv
// Shared types and constants for the BMP ingress parser: FSM states, header
// field offsets, signature bytes and small byte-lane helpers.
package bmp_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_SKIP,
    ST_PIXEL,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int unsigned OFF_FILE_SIZE   = 2;
  localparam int unsigned OFF_DATA_START  = 10;
  localparam int unsigned OFF_WIDTH       = 18;
  localparam int unsigned OFF_HEIGHT      = 22;
  localparam int unsigned OFF_BPP         = 28;
  localparam int unsigned HDR_LAST_WORD   = 28;

  localparam logic [7:0]  SIG_B           = 8'h42;
  localparam logic [7:0]  SIG_M           = 8'h4D;

  localparam int unsigned HDR_MIN_DEFAULT = 54;

  function automatic logic inField(input logic [31:0] off, input int unsigned base,
                                   input int unsigned len);
    return (off >= 32'(base)) && (off < 32'(base + len));
  endfunction

  function automatic logic [1:0] fieldLane(input logic [31:0] off, input int unsigned base);
    return 2'(off - 32'(base));
  endfunction

  function automatic logic [3:0] keepMask(input logic [2:0] cnt);
    case (cnt)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Seven-byte accumulator that compacts lane-masked input bytes and emits
// aligned 32-bit words, with a final partial word on flush.
module byte_packer
  import bmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [3:0]  pushMask_i,
  input  logic [31:0] pushData_i,
  input  logic        flush_i,
  output logic        canPush_o,
  output logic [31:0] outData_o,
  output logic        outValid_o,
  input  logic        outReady_i,
  output logic [3:0]  outKeep_o,
  output logic        outLast_o
);

  logic [7:0]  acc_q [0:6];
  logic [7:0]  acc_d [0:6];
  logic [2:0]  count_q, count_d;
  logic [31:0] data_q;
  logic [3:0]  keep_q;
  logic        last_q, valid_q;

  logic        outFree, popNorm, popFin;
  logic [2:0]  remain;
  logic [3:0]  wrIdx;
  logic [3:0]  loadKeep;
  logic [31:0] loadData;

  // A count of exactly 4 under flush becomes the last word rather than a normal pop.
  assign outFree   = !valid_q || outReady_i;
  assign popFin    = flush_i && outFree && (count_q != 3'd0) && (count_q <= 3'd4);
  assign popNorm   = outFree && (count_q >= 3'd4) && !popFin;
  assign canPush_o = (count_q <= 3'd3) || popNorm;

  always_comb begin
    for (int i = 0; i < 7; i++) acc_d[i] = acc_q[i];
    remain = count_q;
    if (popNorm) begin
      for (int i = 0; i < 3; i++) acc_d[i] = acc_q[i+4];
      remain = count_q - 3'd4;
    end else if (popFin) begin
      remain = 3'd0;
    end
    wrIdx = {1'b0, remain};
    if (push_i) begin
      for (int i = 0; i < 4; i++) begin
        if (pushMask_i[i] && (wrIdx < 4'd7)) begin
          acc_d[wrIdx[2:0]] = pushData_i[8*i +: 8];
          wrIdx = wrIdx + 4'd1;
        end
      end
    end
    count_d = wrIdx[2:0];
  end

  always_comb begin
    loadKeep = popFin ? keepMask(count_q) : 4'b1111;
    for (int j = 0; j < 4; j++) loadData[8*j +: 8] = loadKeep[j] ? acc_q[j] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) acc_q[i] <= 8'h00;
      count_q <= 3'd0;
      data_q  <= 32'h0;
      keep_q  <= 4'h0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      if (popNorm || popFin) begin
        data_q  <= loadData;
        keep_q  <= loadKeep;
        last_q  <= popFin;
        valid_q <= 1'b1;
      end else if (outReady_i) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign outData_o  = data_q;
  assign outKeep_o  = keep_q;
  assign outLast_o  = last_q;
  assign outValid_o = valid_q;

endmodule

// File: rtl/bmp_stream_parser.sv
// BMP file ingress: captures and validates the header, skips to the pixel
// array and hands payload bytes to the packer for the accelerator port.
module bmp_stream_parser
  import bmp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BPP            = 24,
  parameter int unsigned HDR_MIN        = HDR_MIN_DEFAULT,
  parameter int unsigned MAX_FILE_BYTES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_keep,
  output logic                  out_last,
  output logic                  hdr_valid,
  output logic [31:0]           file_size,
  output logic [31:0]           data_start,
  output logic [31:0]           p_width,
  output logic [31:0]           p_height,
  output logic [15:0]           p_bpp,
  output logic                  done,
  output logic                  err
);

  if (DATA_WIDTH != 32) begin : gBadWidth
    $error("bmp_stream_parser supports only DATA_WIDTH = 32");
  end

  state_e      state_q;
  logic [31:0] pos_q;
  logic        chk_q, hdrValid_q, done_q, err_q;
  logic [7:0]  sig0_q, sig1_q, sig0_d, sig1_d;
  logic [31:0] fileSize_q, dataStart_q, width_q, height_q;
  logic [31:0] fileSize_d, dataStart_d, width_d, height_d;
  logic [15:0] bpp_q, bpp_d;

  logic [31:0] laneOff [4];
  logic [7:0]  inByte  [4];
  logic [3:0]  payMask;
  logic        inFire, capture, push, canPush, hdrOk, lastWord, reachesStart;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      laneOff[i] = pos_q + 32'(i);
      inByte[i]  = in_data[8*i +: 8];
      payMask[i] = (laneOff[i] >= dataStart_q) && (laneOff[i] < fileSize_q);
    end
  end

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_HDR, ST_SKIP, ST_ERR: in_ready = 1'b1;
        ST_PIXEL:                in_ready = canPush;
        default:                 in_ready = 1'b0;
      endcase
    end
  end

  assign inFire       = in_valid && in_ready;
  assign capture      = inFire && (state_q == ST_HDR) && !chk_q;
  assign push         = inFire && ((state_q == ST_SKIP) || (state_q == ST_PIXEL));
  assign lastWord     = (pos_q + 32'd4) >= fileSize_q;
  assign reachesStart = (pos_q + 32'd4) > dataStart_q;

  assign hdrOk = (sig0_q == SIG_B) && (sig1_q == SIG_M) && (bpp_q == 16'(BPP)) &&
                 (dataStart_q >= 32'(HDR_MIN)) && (dataStart_q < fileSize_q) &&
                 (fileSize_q <= 32'(MAX_FILE_BYTES));

  // Header bytes land in their field registers as soon as their word arrives.
  always_comb begin
    sig0_d      = sig0_q;
    sig1_d      = sig1_q;
    fileSize_d  = fileSize_q;
    dataStart_d = dataStart_q;
    width_d     = width_q;
    height_d    = height_q;
    bpp_d       = bpp_q;
    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (laneOff[i] == 32'd0) sig0_d = inByte[i];
        if (laneOff[i] == 32'd1) sig1_d = inByte[i];
        if (inField(laneOff[i], OFF_FILE_SIZE, 4))
          fileSize_d[{fieldLane(laneOff[i], OFF_FILE_SIZE), 3'b000} +: 8] = inByte[i];
        if (inField(laneOff[i], OFF_DATA_START, 4))
          dataStart_d[{fieldLane(laneOff[i], OFF_DATA_START), 3'b000} +: 8] = inByte[i];
        if (inField(laneOff[i], OFF_WIDTH, 4))
          width_d[{fieldLane(laneOff[i], OFF_WIDTH), 3'b000} +: 8] = inByte[i];
        if (inField(laneOff[i], OFF_HEIGHT, 4))
          height_d[{fieldLane(laneOff[i], OFF_HEIGHT), 3'b000} +: 8] = inByte[i];
        if (inField(laneOff[i], OFF_BPP, 2))
          bpp_d[{laneOff[i][0], 3'b000} +: 8] = inByte[i];
      end
    end
  end

  // The check cycle keeps accepting words; they are all below any legal data start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_HDR;
      pos_q       <= 32'h0;
      chk_q       <= 1'b0;
      hdrValid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sig0_q      <= 8'h0;
      sig1_q      <= 8'h0;
      fileSize_q  <= 32'h0;
      dataStart_q <= 32'h0;
      width_q     <= 32'h0;
      height_q    <= 32'h0;
      bpp_q       <= 16'h0;
    end else begin
      done_q      <= 1'b0;
      sig0_q      <= sig0_d;
      sig1_q      <= sig1_d;
      fileSize_q  <= fileSize_d;
      dataStart_q <= dataStart_d;
      width_q     <= width_d;
      height_q    <= height_d;
      bpp_q       <= bpp_d;
      if (inFire && (state_q != ST_ERR)) pos_q <= pos_q + 32'd4;
      case (state_q)
        ST_HDR: begin
          if (capture && (pos_q == 32'(HDR_LAST_WORD))) chk_q <= 1'b1;
          if (chk_q) begin
            chk_q <= 1'b0;
            if (hdrOk) begin
              hdrValid_q <= 1'b1;
              state_q    <= ST_SKIP;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end
          end
        end
        ST_SKIP: begin
          if (inFire) begin
            if (lastWord)          state_q <= ST_FLUSH;
            else if (reachesStart) state_q <= ST_PIXEL;
          end
        end
        ST_PIXEL: begin
          if (inFire && lastWord) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (out_valid && out_ready && out_last) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            hdrValid_q <= 1'b0;
            pos_q      <= 32'h0;
          end
        end
        ST_DONE: state_q <= ST_HDR;
        ST_ERR:  err_q   <= 1'b1;
        default: state_q <= ST_HDR;
      endcase
    end
  end

  byte_packer uPacker (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pushMask_i (payMask),
    .pushData_i (in_data),
    .flush_i    (state_q == ST_FLUSH),
    .canPush_o  (canPush),
    .outData_o  (out_data),
    .outValid_o (out_valid),
    .outReady_i (out_ready),
    .outKeep_o  (out_keep),
    .outLast_o  (out_last)
  );

  assign hdr_valid  = hdrValid_q;
  assign file_size  = fileSize_q;
  assign data_start = dataStart_q;
  assign p_width    = width_q;
  assign p_height   = height_q;
  assign p_bpp      = bpp_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
